// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-slot TDM demultiplexer.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int NSLOT = 4;
  localparam int SLOTW = 2;

endpackage

// File: rtl/demux_14_dec.sv
// 1:4 write-enable decoder: turns a slot index plus enable into a one-hot strobe.
module demux_14_dec
  import tdm_pkg::*;
(
  input  logic [SLOTW-1:0] sel,
  input  logic             en,
  output logic [NSLOT-1:0] strobe
);

  // One-hot strobe for the addressed slot, all-zero when disabled.
  always_comb begin
    strobe = '0;
    if (en) strobe[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux_14.sv
// Four-slot TDM demultiplexer: collects one word per valid cycle into shadow
// slots and publishes a complete frame on Y when slot 3 is written.
module tdm_demux_14
  import tdm_pkg::*;
#(
  parameter int W    = 8,
  parameter int ERRW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              frame_start,
  output logic [4*W-1:0]    Y,
  output logic              frame_valid,
  output logic [SLOTW-1:0]  sel,
  output logic              locked,
  output logic              sync_err,
  output logic [ERRW-1:0]   err_cnt
);

  state_t            state, state_nxt;
  logic [W-1:0]      shadow [0:NSLOT-2];
  logic              wr_en;
  logic              misalign;
  logic [SLOTW-1:0]  wr_sel;
  logic [NSLOT-1:0]  strobe;

  // Any frame_start (aligned, misaligned or the HUNT entry) forces a slot-0
  // write, so the write slot collapses to a single mux on frame_start.
  always_comb begin
    wr_en    = din_valid && ((state == LOCK) || frame_start);
    misalign = din_valid && (state == LOCK) && frame_start && (sel != '0);
    wr_sel   = frame_start ? '0 : sel;
  end

  demux_14_dec u_dec (
    .sel    (wr_sel),
    .en     (wr_en),
    .strobe (strobe)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  // Next-state logic: only an accepted frame_start leaves HUNT; LOCK is sticky.
  always_comb begin
    state_nxt = state;
    if (state == HUNT && din_valid && frame_start) state_nxt = LOCK;
  end

  // State-derived outputs.
  always_comb begin
    locked = (state == LOCK);
  end

  // Slot counter, shadow slots, frame output and sync-error tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel         <= '0;
      Y           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      err_cnt     <= '0;
      for (int unsigned i = 0; i < NSLOT - 1; i++) shadow[i] <= '0;
    end else begin
      frame_valid <= strobe[NSLOT-1];
      sync_err    <= misalign;
      if (wr_en) sel <= wr_sel + 2'd1;
      for (int unsigned i = 0; i < NSLOT - 1; i++) begin
        if (strobe[i]) shadow[i] <= din;
      end
      if (strobe[NSLOT-1]) Y <= {din, shadow[2], shadow[1], shadow[0]};
      if (misalign && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
